// File: rtl/fifo_pop_ctrl_pkg.sv
// rtl/fifo_pop_ctrl_pkg.sv - shared state encoding and skid depth for the FIFO read-side controller
package fifo_pop_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_pop_ctrl_pop_skid_buf.sv
// rtl/fifo_pop_ctrl_pop_skid_buf.sv - 2-entry FIFO-order output skid buffer (module pop_skid_buf)
module pop_skid_buf
  import fifo_pop_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  input  logic                  out_ready_i,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic                  head_q;
  logic [1:0]            count_q;
  logic                  push;
  logic                  pop;
  logic                  wr_idx;

  assign in_ready_o  = (count_q != 2'(SKID_DEPTH)) | out_ready_i;
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[head_q];
  assign count_o     = count_q;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  // Tail slot; when full with a same-cycle pop, it is the head slot being freed.
  assign wr_idx      = head_q ^ count_q[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) mem_q[wr_idx] <= in_data_i;
      if (pop) head_q <= ~head_q;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/fifo_pop_ctrl.sv
// rtl/fifo_pop_ctrl.sv - FIFO read-side controller; optional FIFO_POP_CTRL_WATERMARK_EN gates start on watermark
module fifo_pop_ctrl
  import fifo_pop_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_almost_empty,
  input  logic                  fifo_almost_full,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  pop_count
);

  state_e                state_q;
  logic                  inflight_q;
  logic [CNT_WIDTH-1:0]  pop_count_q;
  logic [1:0]            buf_cnt;
  logic                  pop;
  logic                  start;
  logic                  credit_ok;
  logic                  unused_skid_ready;

`ifdef FIFO_POP_CTRL_WATERMARK_EN
  assign start = enable & ~fifo_empty & (~fifo_almost_empty | fifo_almost_full);
`else
  logic unused_flags;
  assign unused_flags = fifo_almost_empty ^ fifo_almost_full;
  assign start = enable & ~fifo_empty;
`endif

  assign pop       = out_valid & out_ready;
  // Buffered plus in-flight words, less this cycle's pop, must leave room for one more.
  assign credit_ok = (3'(buf_cnt) + 3'(inflight_q)) <= (3'(pop) + 3'd1);
  assign fifo_rd   = (state_q == ST_ACTIVE) & enable & ~fifo_empty & credit_ok;
  assign busy      = (state_q != ST_IDLE);
  assign pop_count = pop_count_q;

  pop_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst         (reset_L),
    .in_valid_i  (inflight_q),
    .in_data_i   (fifo_data),
    .in_ready_o  (unused_skid_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ready_i (out_ready),
    .count_o     (buf_cnt)
  );

  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L) begin
      state_q     <= ST_IDLE;
      inflight_q  <= 1'b0;
      pop_count_q <= '0;
    end else begin
      inflight_q <= fifo_rd;
      if (pop) pop_count_q <= pop_count_q + CNT_WIDTH'(1);
      case (state_q)
        ST_IDLE:   if (start) state_q <= ST_ACTIVE;
        ST_ACTIVE: if (!enable || (fifo_empty && !fifo_rd)) state_q <= ST_DRAIN;
        ST_DRAIN:  if (!inflight_q && buf_cnt == 2'd0) state_q <= start ? ST_ACTIVE : ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// tb/tb_fifo_pop_ctrl.sv - directed bench for fifo_pop_ctrl with a queue-backed FIFO RAM model
module tb_fifo_pop_ctrl;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       enable;
  logic       fifo_empty;
  logic       fifo_almost_empty;
  logic       fifo_almost_full;
  logic [3:0] fifo_data;
  logic       fifo_rd;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic [7:0] pop_count;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] q[$];
  logic [3:0] exp_q[$];
  logic       rd_pend = 1'b0;

  always #5 clk = ~clk;

  fifo_pop_ctrl #(
    .DATA_WIDTH(4),
    .CNT_WIDTH (8)
  ) dut (
    .clk              (clk),
    .reset_L          (reset_L),
    .enable           (enable),
    .fifo_empty       (fifo_empty),
    .fifo_almost_empty(fifo_almost_empty),
    .fifo_almost_full (fifo_almost_full),
    .fifo_data        (fifo_data),
    .fifo_rd          (fifo_rd),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy),
    .pop_count        (pop_count)
  );

  // RAM model: a read strobe seen before an edge presents the word just after that edge.
  initial begin
    fifo_empty = 1'b1;
    fifo_data  = 4'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_pend && q.size() > 0) fifo_data = q.pop_front();
      fifo_empty = (q.size() == 0);
      @(negedge clk);
      #1;
      fifo_empty = (q.size() == 0);
      #3;
      rd_pend = fifo_rd;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic load(input logic [3:0] w);
    q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic drain(input string tag);
    logic done;
    logic [3:0] e;
    done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      cyc();
      #2;
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
        chk({tag, "_data"}, 32'(out_data), 32'(e));
      end
      if (!busy && q.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    logic [7:0] exp_rd;
    logic [7:0] exp_ov;
    reset_L           = 1'b1;
    enable            = 1'b0;
    out_ready         = 1'b1;
    fifo_almost_empty = 1'b0;
    fifo_almost_full  = 1'b0;
    cyc();
    cyc();
    reset_L = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_fifo_rd",   32'(fifo_rd),   32'd0);
    chk("rst_pop_count", 32'(pop_count), 32'd0);

    // Streaming 4..7 with downstream always ready.
    cyc();
    load(4'd4); load(4'd5); load(4'd6); load(4'd7);
    enable = 1'b1;
    #2;
    chk("t1_rd_idle", 32'(fifo_rd), 32'd0);
    exp_rd = 8'b0000_1111;
    exp_ov = 8'b0011_1100;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      #2;
      chk($sformatf("t1_rd_%0d", i), 32'(fifo_rd), 32'(exp_rd[i-1]));
      chk($sformatf("t1_ov_%0d", i), 32'(out_valid), 32'(exp_ov[i-1]));
      if (exp_ov[i-1]) chk($sformatf("t1_data_%0d", i), 32'(out_data), 32'(i + 1));
    end
    chk("t1_pop_count", 32'(pop_count), 32'd4);
    chk("t1_busy", 32'(busy), 32'd0);
    exp_q.delete();

    // Downstream stall: two reads fill the buffer, then reads stop.
    cyc();
    load(4'd1); load(4'd2); load(4'd3);
    out_ready = 1'b0;
    #2;
    chk("t2_rd_0", 32'(fifo_rd), 32'd0);
    cyc(); #2; chk("t2_rd_1", 32'(fifo_rd), 32'd1);
    cyc(); #2; chk("t2_rd_2", 32'(fifo_rd), 32'd1);
    cyc(); #2; chk("t2_rd_3", 32'(fifo_rd), 32'd0);
    chk("t2_ov_3", 32'(out_valid), 32'd1);
    chk("t2_data_3", 32'(out_data), 32'd1);
    cyc(); #2; chk("t2_rd_4", 32'(fifo_rd), 32'd0);
    chk("t2_ov_4", 32'(out_valid), 32'd1);
    chk("t2_data_4", 32'(out_data), 32'd1);
    cyc();
    out_ready = 1'b1;
    #2;
    chk("t2_data_5", 32'(out_data), 32'd1);
    chk("t2_rd_5", 32'(fifo_rd), 32'd1);
    cyc(); #2; chk("t2_data_6", 32'(out_data), 32'd2);
    cyc(); #2; chk("t2_data_7", 32'(out_data), 32'd3);
    chk("t2_busy_7", 32'(busy), 32'd1);
    cyc(); #2; chk("t2_ov_8", 32'(out_valid), 32'd0);
    chk("t2_pop_count", 32'(pop_count), 32'd7);
    cyc(); #2; chk("t2_busy_9", 32'(busy), 32'd0);
    enable = 1'b0;
    exp_q.delete();

    // Enable dropped right after a read: in-flight word still delivered.
    cyc();
    load(4'd8); load(4'd9); load(4'd10);
    enable = 1'b1;
    #2;
    cyc(); #2; chk("t3_rd_1", 32'(fifo_rd), 32'd1);
    cyc();
    enable = 1'b0;
    #2;
    chk("t3_rd_2", 32'(fifo_rd), 32'd0);
    cyc(); #2;
    chk("t3_ov_3", 32'(out_valid), 32'd1);
    chk("t3_data_3", 32'(out_data), 32'd8);
    chk("t3_rd_3", 32'(fifo_rd), 32'd0);
    cyc(); #2;
    chk("t3_ov_4", 32'(out_valid), 32'd0);
    chk("t3_busy_4", 32'(busy), 32'd1);
    cyc(); #2;
    chk("t3_busy_5", 32'(busy), 32'd0);
    chk("t3_pop_count", 32'(pop_count), 32'd8);
    exp_q.delete();

    // Async reset with the buffer full.
    cyc();
    load(4'd11);
    out_ready = 1'b0;
    enable = 1'b1;
    #2;
    cyc(); #2;
    cyc(); #2;
    cyc(); #2;
    cyc(); #2;
    chk("t4_ov_full", 32'(out_valid), 32'd1);
    chk("t4_data_full", 32'(out_data), 32'd9);
    chk("t4_rd_full", 32'(fifo_rd), 32'd0);
    reset_L = 1'b1;
    #1;
    chk("t4_rst_ov", 32'(out_valid), 32'd0);
    chk("t4_rst_rd", 32'(fifo_rd), 32'd0);
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_pop_count", 32'(pop_count), 32'd0);
    cyc();
    q.delete();
    exp_q.delete();
    enable = 1'b0;
    out_ready = 1'b1;
    reset_L = 1'b0;
    #2;
    chk("t4_post_ov_0", 32'(out_valid), 32'd0);
    cyc(); #2;
    chk("t4_post_ov_1", 32'(out_valid), 32'd0);
    chk("t4_post_busy_1", 32'(busy), 32'd0);

    // pop_count wrap.
    cyc();
    for (int i = 0; i < 255; i++) load(4'(i));
    enable = 1'b1;
    drain("t5_stream");
    chk("t5_pop_count_255", 32'(pop_count), 32'd255);
    cyc();
    load(4'd12);
    drain("t5_wrap");
    chk("t5_pop_count_wrap", 32'(pop_count), 32'd0);

    // Watermark-gated start.
    cyc();
    load(4'd13); load(4'd14); load(4'd15);
    fifo_almost_empty = 1'b1;
    fifo_almost_full  = 1'b0;
    #2;
    chk("t6_busy_0", 32'(busy), 32'd0);
    chk("t6_rd_0", 32'(fifo_rd), 32'd0);
    cyc(); #2;
`ifdef FIFO_POP_CTRL_WATERMARK_EN
    chk("t6_hold_busy", 32'(busy), 32'd0);
    chk("t6_hold_rd", 32'(fifo_rd), 32'd0);
    cyc();
    fifo_almost_full = 1'b1;
    #2;
    chk("t6_af_busy_0", 32'(busy), 32'd0);
    cyc(); #2;
    chk("t6_af_busy_1", 32'(busy), 32'd1);
    chk("t6_af_rd_1", 32'(fifo_rd), 32'd1);
`else
    chk("t6_start_busy", 32'(busy), 32'd1);
    chk("t6_start_rd", 32'(fifo_rd), 32'd1);
`endif
    drain("t6_drain");
    chk("t6_pop_count", 32'(pop_count), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
